// File: rtl/sign_extension_pkg.sv
// sign_extension_pkg: shared widths for the decode-stage immediate extender
package sign_extension_pkg;
  localparam int REG_WIDTH = 32;
  localparam int IMM_WIDTH = 16;
  localparam int OFFSET_SHIFT = 2;
endpackage

// File: rtl/sign_ext_core.sv
// sign_ext_core: parameterised immediate extender with zero/sign select
module sign_ext_core #(
  parameter int IN_WIDTH = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]  imm,
  input  logic                 zero_ext,
  output logic [OUT_WIDTH-1:0] ext
);
  assign ext = {{(OUT_WIDTH-IN_WIDTH){imm[IN_WIDTH-1] & ~zero_ext}}, imm};
endmodule

// File: rtl/sign_extension.sv
// sign_extension: combinational sign extension plus a lock-gated staged immediate and word offset
module sign_extension
  import sign_extension_pkg::*;
#(
  parameter int IN_WIDTH = IMM_WIDTH,
  parameter int OUT_WIDTH = REG_WIDTH
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESET_N,
  input  logic [IN_WIDTH-1:0]  In,
  output logic [OUT_WIDTH-1:0] Out,
  input  logic                 I_LOCK,
  input  logic                 I_ZeroExt,
  output logic [OUT_WIDTH-1:0] O_ImmQ,
  output logic [OUT_WIDTH-1:0] O_OffsetQ,
  output logic                 O_ValidQ
);
  logic [OUT_WIDTH-1:0] ext;
  if (OUT_WIDTH <= IN_WIDTH + OFFSET_SHIFT) begin : g_width_check
    $error("sign_extension: OUT_WIDTH must exceed IN_WIDTH + 2");
  end
  sign_ext_core #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_comb (
    .imm(In),
    .zero_ext(1'b0),
    .ext(Out)
  );
  sign_ext_core #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_stage (
    .imm(In),
    .zero_ext(I_ZeroExt),
    .ext(ext)
  );
  // offset drops the top bits on purpose: branch targets wrap, they never saturate
  always_ff @(posedge I_CLOCK or negedge I_RESET_N)
    if (!I_RESET_N) begin
      O_ImmQ <= '0;
      O_OffsetQ <= '0;
      O_ValidQ <= 1'b0;
    end else if (I_LOCK) begin
      O_ImmQ <= ext;
      O_OffsetQ <= {ext[OUT_WIDTH-OFFSET_SHIFT-1:0], {OFFSET_SHIFT{1'b0}}};
      O_ValidQ <= 1'b1;
    end
endmodule

// File: tb/tb_sign_extension.sv
// tb_sign_extension: randomized scoreboard bench for sign_extension against an arithmetic reference model
module tb_sign_extension;
  logic clk = 0, rst_n = 0, lock = 0, ze = 0;
  logic [15:0] in = 0;
  logic [31:0] out, imm_q, off_q;
  logic valid_q;
  int total = 0, bad = 0;

  typedef struct {
    logic [15:0] in;
    logic [31:0] out;
    logic [31:0] imm;
    logic [31:0] off;
    logic        v;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] m_imm = 0, m_off = 0;
  logic m_v = 0;

  sign_extension dut (
    .I_CLOCK(clk),
    .I_RESET_N(rst_n),
    .In(in),
    .Out(out),
    .I_LOCK(lock),
    .I_ZeroExt(ze),
    .O_ImmQ(imm_q),
    .O_OffsetQ(off_q),
    .O_ValidQ(valid_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
    end
  endtask

  // numeric value of the immediate, reduced modulo 2^32
  function automatic logic [31:0] ref_ext(input logic [15:0] x, input bit z);
    longint v = x;
    if (!z && x >= 16'h8000) v = v - 65536;
    return 32'(v);
  endfunction

  task automatic step(input bit r, input bit l, input bit z, input logic [15:0] x);
    @(negedge clk);
    rst_n = r; lock = l; ze = z; in = x;
    if (!r) begin
      m_imm = 0; m_off = 0; m_v = 0;
    end else if (l) begin
      m_imm = ref_ext(x, z);
      m_off = m_imm * 4;
      m_v = 1;
    end
    q.push_back('{x, ref_ext(x, 1'b0), m_imm, m_off, m_v});
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_out", out, e.out);
      chk("sb_imm", imm_q, e.imm);
      chk("sb_off", off_q, e.off);
      chk("sb_valid", {31'b0, valid_q}, {31'b0, e.v});
    end
  end

  initial begin
    logic [15:0] sw_in[4] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [31:0] sw_out[4] = '{32'h00000000, 32'h00007FFF, 32'hFFFF8000, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      in = sw_in[i];
      #1;
      chk("comb_in_reset", out, sw_out[i]);
    end
    chk("rst_imm", imm_q, 0);
    chk("rst_off", off_q, 0);
    chk("rst_valid", {31'b0, valid_q}, 0);
    step(0, 0, 0, 16'h0000);
    step(1, 1, 0, 16'hFFFF);
    @(posedge clk); #2;
    chk("sign_imm", imm_q, 32'hFFFFFFFF);
    chk("sign_off", off_q, 32'hFFFFFFFC);
    chk("sign_valid", {31'b0, valid_q}, 1);
    step(1, 1, 1, 16'h8001);
    @(posedge clk); #2;
    chk("zero_imm", imm_q, 32'h00008001);
    chk("zero_off", off_q, 32'h00020004);
    chk("zero_out", out, 32'hFFFF8001);
    step(1, 1, 0, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 16'h1234);
      @(posedge clk); #2;
      chk("hold_imm", imm_q, 32'h00000010);
      chk("hold_off", off_q, 32'h00000040);
    end
    rst_n = 0;
    m_imm = 0; m_off = 0; m_v = 0;
    #1;
    chk("async_imm", imm_q, 0);
    chk("async_off", off_q, 0);
    chk("async_valid", {31'b0, valid_q}, 0);
    step(0, 1, 0, 16'h5555);
    step(1, 0, 0, 16'h2222);
    @(posedge clk); #2;
    chk("post_rst_nolock_valid", {31'b0, valid_q}, 0);
    step(1, 1, 0, 16'h7FFF);
    @(posedge clk); #2;
    chk("recap_imm", imm_q, 32'h00007FFF);
    chk("recap_off", off_q, 32'h0001FFFC);
    chk("recap_valid", {31'b0, valid_q}, 1);
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           16'($urandom));
    @(posedge clk); #2;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
